// File: rtl/keysched128.sv
// ---------------------------------------------------------------------------
// keysched128 -- forward AES-128 key scheduler with a consumer handshake.
//
// Loads a 128-bit cipher key on start and presents round keys 0..10 one per
// accepted handshake (keyValid & advance). The round-10 key is captured in
// lastKey, where it seeds the inverse-cipher key expansion.
//
// Ports
//   clk       in   1    system clock, rising edge
//   reset     in   1    synchronous active-high reset
//   start     in   1    load key and begin a new schedule (any state)
//   key       in   128  cipher key, sampled with start
//   advance   in   1    consumer accepts the current round key
//   roundKey  out  128  current round key, word 0 in [127:96]
//   round     out  4    index of roundKey, 0..10
//   keyValid  out  1    roundKey/round are valid
//   done      out  1    all 11 round keys have been accepted
//   lastKey   out  128  round-10 key, captured when round 10 is accepted
// ---------------------------------------------------------------------------
module keysched128 (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         advance,
    output logic [127:0] roundKey,
    output logic [3:0]   round,
    output logic         keyValid,
    output logic         done,
    output logic [127:0] lastKey
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Four parallel S-box lookups, one per byte of the word.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]   state_q,   state_d;
    logic [127:0] block_q,   block_d;
    logic [7:0]   rcon_q,    rcon_d;
    logic [3:0]   round_q,   round_d;
    logic [127:0] lastkey_q, lastkey_d;

    // Next round key from the current one.
    logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [127:0] next_block;

    always_comb begin
        w0 = block_q[127:96];
        w1 = block_q[95:64];
        w2 = block_q[63:32];
        w3 = block_q[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_block = {n0, n1, n2, n3};
    end

    // NOTE: every next-state signal takes its current value first, so no
    // branch below can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        block_d   = block_q;
        rcon_d    = rcon_q;
        round_d   = round_q;
        lastkey_d = lastkey_q;

        if (start) begin
            // Restart wins over a pending handshake in every state.
            state_d = ST_RUN;
            block_d = key;
            rcon_d  = 8'h01;
            round_d = 4'd0;
        end else if (state_q == ST_RUN && advance) begin
            if (round_q == LAST_ROUND) begin
                lastkey_d = block_q;
                state_d   = ST_DONE;
            end else begin
                block_d = next_block;
                round_d = round_q + 4'd1;
                // Rcon for round 10 (8'h36) is the last one needed; leave it there.
                if (round_q != LAST_ROUND - 4'd1) begin
                    rcon_d = xtime(rcon_q);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            block_q   <= '0;
            rcon_q    <= 8'h01;
            round_q   <= 4'd0;
            lastkey_q <= '0;
        end else begin
            state_q   <= state_d;
            block_q   <= block_d;
            rcon_q    <= rcon_d;
            round_q   <= round_d;
            lastkey_q <= lastkey_d;
        end
    end

    assign roundKey = block_q;
    assign round    = round_q;
    assign keyValid = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign lastKey  = lastkey_q;

endmodule

// File: tb/tb_keysched128.sv
// ---------------------------------------------------------------------------
// tb_keysched128 -- directed self-checking bench for keysched128.
// Expected round keys are the published AES-128 expansions of the FIPS-197
// example key and of the all-zero key.
// ---------------------------------------------------------------------------
module tb_keysched128;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         advance;
    logic [127:0] roundKey;
    logic [3:0]   round;
    logic         keyValid;
    logic         done;
    logic [127:0] lastKey;

    keysched128 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .advance  (advance),
        .roundKey (roundKey),
        .round    (round),
        .keyValid (keyValid),
        .done     (done),
        .lastKey  (lastKey)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] fips_rk [11];
    logic [127:0] zero_r1;
    logic [127:0] zero_r10;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, 128'(keyValid), 128'd0);
        check({tag, ".done"},  128'(done),     128'd0);
        check({tag, ".round"}, 128'(round),    128'd0);
        check({tag, ".key"},   roundKey,       128'd0);
    endtask

    task automatic check_done(input string tag, input logic [127:0] rk10);
        check({tag, ".done"},    128'(done),     128'd1);
        check({tag, ".valid"},   128'(keyValid), 128'd0);
        check({tag, ".round"},   128'(round),    128'd10);
        check({tag, ".key"},     roundKey,       rk10);
        check({tag, ".lastKey"}, lastKey,        rk10);
    endtask

    initial begin
        fips_rk = '{
            128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'ha0fafe1788542cb123a339392a6c7605,
            128'hf2c295f27a96b9435935807a7359f67f,
            128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hef44a541a8525b7fb671253bdb0bad00,
            128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'h6d88a37a110b3efddbf98641ca0093fd,
            128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'head27321b58dbad2312bf5607f8d292f,
            128'hac7766f319fadc2128d12941575c006e,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6
        };
        zero_r1  = 128'h62636363626363636263636362636363;
        zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        // Reset dominates a simultaneous start.
        reset   = 1'b1;
        start   = 1'b1;
        advance = 1'b1;
        key     = fips_rk[0];
        step();
        check_idle_outputs("reset");
        check("reset.lastKey", lastKey, 128'd0);

        reset   = 1'b0;
        start   = 1'b0;
        advance = 1'b0;
        step();
        check_idle_outputs("post_reset");

        // advance pulses in IDLE are ignored.
        advance = 1'b1;
        step();
        advance = 1'b0;
        step();
        check_idle_outputs("idle_adv");

        // Streaming schedule: rounds 0..10 in consecutive cycles, done on the 12th.
        start   = 1'b1;
        advance = 1'b1;
        key     = fips_rk[0];
        step();
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("stream.valid%0d", i), 128'(keyValid), 128'd1);
            check($sformatf("stream.round%0d", i), 128'(round),    128'(i));
            check($sformatf("stream.key%0d", i),   roundKey,       fips_rk[i]);
            step();
        end
        check_done("stream_done", fips_rk[10]);

        // advance in DONE changes nothing.
        advance = 1'b0;
        step();
        advance = 1'b1;
        step();
        advance = 1'b0;
        step();
        check_done("done_adv", fips_rk[10]);

        // Stalls: the key and index hold through every gap.
        start = 1'b1;
        key   = fips_rk[0];
        step();
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                check($sformatf("stall.round%0d", i), 128'(round), 128'(i));
                check($sformatf("stall.key%0d", i),   roundKey,    fips_rk[i]);
            end
            check($sformatf("stall.valid%0d", i), 128'(keyValid), 128'd1);
            advance = 1'b1;
            step();
            advance = 1'b0;
        end
        check_done("stall_done", fips_rk[10]);

        // Restart from DONE, then abort at round 5 with the all-zero key.
        start   = 1'b1;
        advance = 1'b1;
        key     = fips_rk[0];
        step();
        start = 1'b0;
        step(); step(); step(); step(); step();
        check("mid.round5", 128'(round), 128'd5);
        check("mid.key5",   roundKey,    fips_rk[5]);
        start = 1'b1;
        key   = '0;
        step();
        start = 1'b0;
        check("restart.round", 128'(round),    128'd0);
        check("restart.key",   roundKey,       128'd0);
        check("restart.valid", 128'(keyValid), 128'd1);
        check("restart.last",  lastKey,        fips_rk[10]);
        step();
        check("zero.round1", 128'(round), 128'd1);
        check("zero.key1",   roundKey,    zero_r1);
        for (int i = 2; i <= 10; i++) step();
        check("zero.key10",  roundKey,    zero_r10);
        check("zero.last_hold", lastKey,  fips_rk[10]);
        step();
        check_done("zero_done", zero_r10);

        // Restart from DONE with the all-zero key again.
        start = 1'b1;
        key   = '0;
        step();
        start = 1'b0;
        check("redo.key0", roundKey, 128'd0);
        step();
        check("redo.key1", roundKey, zero_r1);
        for (int i = 2; i <= 10; i++) step();
        check("redo.key10", roundKey, zero_r10);
        step();
        check_done("redo_done", zero_r10);

        // Reset mid-schedule aborts and clears lastKey.
        start = 1'b1;
        key   = fips_rk[0];
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset   = 1'b0;
        advance = 1'b0;
        check_idle_outputs("reset_mid");
        check("reset_mid.lastKey", lastKey, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
